// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-stage definitions.
// - INST_NOP: canonical bubble (addi x0, x0, 0) that is presented when no instruction is valid.
// - fetch_state_e: fetch controller states.
// - fetch_fault_e: fetch fault-type encoding, shared with the trap unit.
package inst_fetch_unit_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    StFetch,
    StWait,
    StHold,
    StDrop,
    StFault,
    StHalt
  } fetch_state_e;

  typedef enum logic {
    FaultBusErr     = 1'b0,
    FaultMisaligned = 1'b1
  } fetch_fault_e;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage. Owns the fetch PC, issues word reads on the instruction bus
// (req/gnt/rvalid, one outstanding) and presents one instruction per cycle to IF/ID.
// Ports:
//   clk, rst_sync                  - core clock, synchronous active-high reset
//   stall_n                        - 0: decode stalled, the presented slot is not consumed
//   redirect_en, redirect_addr     - control-flow redirect (highest priority)
//   ibus_req/addr/gnt              - bus request channel
//   ibus_rvalid/rdata/err          - bus response channel (err qualified by rvalid)
//   instruction_addr_if/_if        - presented slot address and word (INST_NOP when empty)
//   exception_if_raise             - fetch fault, asserted only in the consuming cycle
//   exc_misaligned_if              - fault type: 1 misaligned, 0 bus error
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          BACK_TO_BACK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_sync,
  input  logic        stall_n,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err,
  output logic [31:0] instruction_addr_if,
  output logic [31:0] instruction_if,
  output logic        exception_if_raise,
  output logic        exc_misaligned_if
);

  fetch_state_e state_q, state_d;
  fetch_fault_e fault_q, fault_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic [31:0]  pc_next;
  logic         req;

  // Wraps modulo 2^32 by construction.
  assign pc_next = pc_q + 32'd4;

  always_comb begin
    state_d             = state_q;
    fault_d             = fault_q;
    pc_d                = pc_q;
    hold_inst_d         = hold_inst_q;
    req                 = 1'b0;
    ibus_addr           = pc_q;
    instruction_if      = INST_NOP;
    instruction_addr_if = pc_q;
    exception_if_raise  = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = StFault;
          fault_d = FaultMisaligned;
        end else begin
          req = 1'b1;
          if (ibus_gnt) state_d = StWait;
        end
      end
      StWait: begin
        if (ibus_rvalid) begin
          if (ibus_err) begin
            state_d = StFault;
            fault_d = FaultBusErr;
          end else begin
            instruction_if = ibus_rdata;
            if (stall_n) begin
              pc_d = pc_next;
              // Overlap the next request with consumption; a redirect would orphan it.
              if (BACK_TO_BACK && !redirect_en) begin
                req       = 1'b1;
                ibus_addr = pc_next;
                state_d   = ibus_gnt ? StWait : StFetch;
              end else begin
                state_d = StFetch;
              end
            end else begin
              hold_inst_d = ibus_rdata;
              state_d     = StHold;
            end
          end
        end
      end
      StHold: begin
        instruction_if = hold_inst_q;
        if (stall_n) begin
          pc_d    = pc_next;
          state_d = StFetch;
        end
      end
      StFault: begin
        exception_if_raise = stall_n;
        if (stall_n) state_d = StHalt;
      end
      StHalt: begin
        state_d = StHalt;
      end
      StDrop: begin
        if (ibus_rvalid) state_d = StFetch;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    // Redirect beats everything; an in-flight response must be drained in StDrop.
    if (redirect_en) begin
      pc_d               = redirect_addr;
      instruction_if     = INST_NOP;
      exception_if_raise = 1'b0;
      if (state_q == StWait) begin
        state_d = ibus_rvalid ? StFetch : StDrop;
      end else if (state_q == StFetch) begin
        state_d = (req && ibus_gnt) ? StDrop : StFetch;
      end else if (state_q != StDrop) begin
        state_d = StFetch;
      end
    end

    if (rst_sync) begin
      req                 = 1'b0;
      instruction_if      = INST_NOP;
      instruction_addr_if = RESET_PC;
      exception_if_raise  = 1'b0;
    end
  end

  assign ibus_req          = req;
  assign exc_misaligned_if = (fault_q == FaultMisaligned);

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q     <= StFetch;
      fault_q     <= FaultBusErr;
      pc_q        <= RESET_PC;
      hold_inst_q <= INST_NOP;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      pc_q        <= pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit. The reference model is program order:
// after a reset or redirect to R the consumed slots must be R, R+4, ... with the memory
// word at each address, ending at the first fault (misaligned R or bus-error address).
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_sync, stall_n, redirect_en;
  logic [31:0] redirect_addr;
  logic        ibus_req, ibus_gnt, ibus_rvalid, ibus_err;
  logic [31:0] ibus_addr, ibus_rdata;
  logic [31:0] instruction_addr_if, instruction_if;
  logic        exception_if_raise, exc_misaligned_if;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .RESET_PC    (RST_PC),
    .BACK_TO_BACK(1'b1)
  ) dut (
    .clk                (clk),
    .rst_sync           (rst_sync),
    .stall_n            (stall_n),
    .redirect_en        (redirect_en),
    .redirect_addr      (redirect_addr),
    .ibus_req           (ibus_req),
    .ibus_addr          (ibus_addr),
    .ibus_gnt           (ibus_gnt),
    .ibus_rvalid        (ibus_rvalid),
    .ibus_rdata         (ibus_rdata),
    .ibus_err           (ibus_err),
    .instruction_addr_if(instruction_addr_if),
    .instruction_if     (instruction_if),
    .exception_if_raise (exception_if_raise),
    .exc_misaligned_if  (exc_misaligned_if)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    bit          exc;
    bit          mis;
  } slot_t;

  slot_t exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  bit    halted = 1'b0;

  // Memory contents: a fixed hash of the address, never equal to the NOP bubble.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a ^ 32'h5bd1_e995) * 32'h9e37_79b1;
    w = w ^ (w >> 15);
    if (w == INST_NOP) w = 32'hdead_beef;
    return w;
  endfunction

  function automatic bit bus_err(input logic [31:0] a);
    return ((a >> 2) % 19) == 7;
  endfunction

  task automatic check(input bit ok, input string name, input string act, input string req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, required %s (t=%0t)", name, act, req, $time);
  endtask

  // Replace the expected stream with the program-order slots starting at r.
  task automatic push_stream(input logic [31:0] r, input int k);
    logic [31:0] a;
    exp_q.delete();
    halted = 1'b0;
    if (r[1:0] != 2'b00) begin
      exp_q.push_back('{addr: r, inst: INST_NOP, exc: 1'b1, mis: 1'b1});
      return;
    end
    for (int i = 0; i < k; i++) begin
      a = r + 32'(4 * i);
      if (bus_err(a)) begin
        exp_q.push_back('{addr: a, inst: INST_NOP, exc: 1'b1, mis: 1'b0});
        return;
      end
      exp_q.push_back('{addr: a, inst: mem_word(a), exc: 1'b0, mis: 1'b0});
    end
  endtask

  // ---------------- Bus responder: one outstanding, 1..3 cycle latency ----------------
  initial begin
    logic        hs, rv, was_rst, pending;
    logic [31:0] hs_addr, p_addr;
    int          delay;
    pending = 1'b0; p_addr = '0; delay = 0;
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0; ibus_err = 1'b0;
    forever begin
      @(negedge clk);
      hs      = ibus_req && ibus_gnt;
      hs_addr = ibus_addr;
      rv      = ibus_rvalid;
      was_rst = rst_sync;
      if (hs && !was_rst)
        check(!pending || rv, "one_outstanding", "second request", "at most one");
      @(posedge clk);
      #1;
      if (was_rst) begin
        pending = 1'b0;
      end else begin
        if (rv) pending = 1'b0;
        if (hs) begin
          pending = 1'b1;
          p_addr  = hs_addr;
          delay   = int'($urandom % 3);
        end
      end
      ibus_gnt = ($urandom % 10) < 7;
      if (pending && delay == 0) begin
        ibus_rvalid = 1'b1;
        ibus_rdata  = mem_word(p_addr);
        ibus_err    = bus_err(p_addr);
      end else begin
        if (pending) delay--;
        ibus_rvalid = 1'b0;
        ibus_rdata  = $urandom;
        ibus_err    = 1'($urandom % 2);
      end
    end
  end

  // ---------------- Monitor: pops the scoreboard on every consumed slot ----------------
  bit          prev_held, prev_req;
  logic [31:0] prev_inst, prev_addr, prev_req_addr;

  always @(negedge clk) begin
    bit    consume;
    slot_t e;
    if (rst_sync) begin
      check(ibus_req == 1'b0, "reset_req", $sformatf("%b", ibus_req), "0");
      check(instruction_if == INST_NOP, "reset_inst", $sformatf("%h", instruction_if),
            $sformatf("%h", INST_NOP));
      check(instruction_addr_if == RST_PC, "reset_addr", $sformatf("%h", instruction_addr_if),
            $sformatf("%h", RST_PC));
      check(exception_if_raise == 1'b0, "reset_exc", $sformatf("%b", exception_if_raise), "0");
      prev_held = 1'b0;
      prev_req  = 1'b0;
    end else begin
      consume = stall_n && !redirect_en && (instruction_if != INST_NOP || exception_if_raise);
      if (exception_if_raise)
        check(stall_n && !redirect_en, "raise_only_when_consumed",
              $sformatf("stall_n=%b redirect=%b", stall_n, redirect_en), "stall_n=1 redirect=0");
      if (prev_held && !redirect_en)
        check(instruction_if == prev_inst && instruction_addr_if == prev_addr, "held_stable",
              $sformatf("%h@%h", instruction_if, instruction_addr_if),
              $sformatf("%h@%h", prev_inst, prev_addr));
      if (prev_req)
        check(ibus_req && ibus_addr == prev_req_addr, "req_held_until_gnt",
              $sformatf("req=%b addr=%h", ibus_req, ibus_addr),
              $sformatf("req=1 addr=%h", prev_req_addr));
      if (consume) begin
        check(exp_q.size() != 0, "slot_expected",
              $sformatf("%h@%h exc=%b", instruction_if, instruction_addr_if, exception_if_raise),
              "no slot");
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(instruction_addr_if == e.addr && instruction_if == e.inst &&
                exception_if_raise == e.exc && (!e.exc || exc_misaligned_if == e.mis),
                "slot",
                $sformatf("%h@%h exc=%b mis=%b", instruction_if, instruction_addr_if,
                          exception_if_raise, exc_misaligned_if),
                $sformatf("%h@%h exc=%b mis=%b", e.inst, e.addr, e.exc, e.mis));
          if (e.exc) halted = 1'b1;
        end
      end
      prev_held     = !consume && !redirect_en && instruction_if != INST_NOP;
      prev_inst     = instruction_if;
      prev_addr     = instruction_addr_if;
      prev_req      = ibus_req && !ibus_gnt && !redirect_en;
      prev_req_addr = ibus_addr;
    end
  end

  // ---------------- Stimulus ----------------
  // Once the expected stream is used up, stall decode so nothing further is consumed,
  // except after a fault where the unit must sit in HALT producing nothing.
  task automatic step();
    stall_n = (exp_q.size() != 0 || halted) ? ($urandom % 4 != 0) : 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_segment();
    int early, n;
    early = ($urandom % 3 == 0) ? int'($urandom_range(0, 5)) : -1;
    n = 0;
    while (exp_q.size() != 0 && n != early && n < 400) begin
      step();
      n++;
    end
    if (early < 0)
      check(exp_q.size() == 0, "stream_drained", $sformatf("%0d left", exp_q.size()), "0 left");
    repeat ($urandom_range(0, 4)) step();
  endtask

  initial begin
    logic [31:0] a;
    int          k, r;
    rst_sync = 1'b1; stall_n = 1'b0; redirect_en = 1'b0; redirect_addr = '0;
    push_stream(RST_PC, 6);
    repeat (3) @(posedge clk);
    #1;
    rst_sync = 1'b0;
    for (int seg = 0; seg < 150; seg++) begin
      run_segment();
      k = int'($urandom_range(1, 8));
      r = int'($urandom % 10);
      if (r == 0) begin
        rst_sync    = 1'b1;
        redirect_en = 1'b0;
        stall_n     = 1'($urandom % 2);
        push_stream(RST_PC, k);
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
        rst_sync = 1'b0;
      end else begin
        if (r == 1) a = ($urandom & 32'h0000_0FFC) | 32'(($urandom % 3) + 1);
        else if (r == 2) a = 32'hFFFF_FFF0 + 32'(4 * ($urandom % 4));
        else a = $urandom & 32'h0000_FFFC;
        redirect_en   = 1'b1;
        redirect_addr = a;
        stall_n       = 1'($urandom % 2);
        push_stream(a, k);
        @(posedge clk);
        #1;
        redirect_en   = 1'b0;
        redirect_addr = $urandom;
      end
    end
    run_segment();
    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
